sync_fifo: RTL and testbench

// - Parametrised single-clock FIFO: write/read pointers, occupancy counter,

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 30 +++
 rtl/sync_fifo.sv | 121 ++++++++++++
 tb/tb_sync_fifo.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: default geometry, flag bundle and the flag derivation helper.
// Imported by sync_fifo and fifo_mem so every FIFO instance agrees on sizing.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_ADDR_WIDTH = 3;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Flags for a given occupancy; also used to build the reset values.
    function automatic fifo_flags_t calc_flags(input int count, input int depth,
                                               input int af_margin, input int ae_margin);
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.almost_full  = (count >= depth - af_margin);
        f.almost_empty = (count <= ae_margin);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_WIDTH x DEPTH storage with synchronous write and registered read.
// No reset: contents and read register are undefined until written.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, registered flags and registered read data.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam fifo_flags_t RST_FLAGS = calc_flags(0, DEPTH, AF_MARGIN, AE_MARGIN);

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  data_valid_q;
    logic                  rd_seen_q;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign pop_ok  = pop & ~flags_q.empty;
    assign push_ok = push & (~flags_q.full | pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        flags_d = calc_flags(int'(count_d), DEPTH, AF_MARGIN, AE_MARGIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flags_q      <= RST_FLAGS;
            data_valid_q <= 1'b0;
            rd_seen_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_seen_q <= 1'b1;
            end
            count_q      <= count_d;
            flags_q      <= flags_d;
            data_valid_q <= pop_ok;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (Fifo_Data_in),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // The unreset read register is masked until the first pop after reset.
    assign Fifo_Data_out = rd_seen_q ? mem_rdata : '0;
    assign data_valid    = data_valid_q;
    assign full          = flags_q.full;
    assign empty         = flags_q.empty;
    assign almost_full   = flags_q.almost_full;
    assign almost_empty  = flags_q.almost_empty;
    assign fifo_count    = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && flags_q.full && !pop) overflow_q  <= 1'b1;
            if (pop && flags_q.empty)         underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default geometry: 10-bit x 8).
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [9:0] Fifo_Data_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [9:0] Fifo_Data_out;
    logic       data_valid, full, empty, almost_full, almost_empty;
    logic [3:0] fifo_count;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int tests_run = 0;
    int failed    = 0;

    sync_fifo dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .Fifo_Data_in  (Fifo_Data_in),
        .push          (push),
        .pop           (pop),
        .Fifo_Data_out (Fifo_Data_out),
        .data_valid    (data_valid),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .fifo_count    (fifo_count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow      (overflow),
        .underflow     (underflow)
`endif
    );

    always #5 clk = ~clk;

    // {full, empty, almost_full, almost_empty, count}
    function automatic logic [7:0] stat();
        return {full, empty, almost_full, almost_empty, fifo_count};
    endfunction

    function automatic logic [7:0] exp_stat(input int c);
        logic [3:0] c4;
        c4 = 4'(c);
        return {c == 8, c == 0, c >= 7, c <= 1, c4};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; pop = 0;
        reset_L = 0;
        step(); step();
        reset_L = 1;
        step(); step(); step();
    endtask

    task automatic test_reset();
        do_reset();
        push = 1;
        for (int i = 0; i < 3; i++) begin
            Fifo_Data_in = 10'(i + 'h30);
            step();
        end
        pop = 1;
        step();
        reset_L = 0;
        #2;
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(0), 1'b0, 10'h000}) begin
            failed++;
            $display("FAIL reset_async: got stat=%h valid=%b data=%h, expected stat=%h valid=0 data=000",
                     stat(), data_valid, Fifo_Data_out, exp_stat(0));
        end
        step(); step();
        push = 0; pop = 0;
        reset_L = 1;
        step(); step(); step();
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(0), 1'b0, 10'h000}) begin
            failed++;
            $display("FAIL reset_release: got stat=%h valid=%b data=%h, expected stat=%h valid=0 data=000",
                     stat(), data_valid, Fifo_Data_out, exp_stat(0));
        end
        pop = 1;
        step();
        pop = 0;
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(0), 1'b0, 10'h000}) begin
            failed++;
            $display("FAIL reset_pop_ignored: got stat=%h valid=%b data=%h, expected stat=%h valid=0 data=000",
                     stat(), data_valid, Fifo_Data_out, exp_stat(0));
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        push = 1;
        for (int i = 1; i <= 8; i++) begin
            Fifo_Data_in = 10'(i);
            step();
            tests_run++;
            if (stat() !== exp_stat(i)) begin
                failed++;
                $display("FAIL fill_%0d: got stat=%h, expected %h", i, stat(), exp_stat(i));
            end
        end
        Fifo_Data_in = 10'h3FF;
        step();
        push = 0;
        tests_run++;
        if (stat() !== exp_stat(8)) begin
            failed++;
            $display("FAIL fill_overpush: got stat=%h, expected %h", stat(), exp_stat(8));
        end
`ifdef SYNC_FIFO_ERR_EN
        tests_run++;
        if (overflow !== 1'b1) begin
            failed++;
            $display("FAIL overflow_set: got %b, expected 1", overflow);
        end
`endif
        pop = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            tests_run++;
            if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(8 - i), 1'b1, 10'(i)}) begin
                failed++;
                $display("FAIL drain_%0d: got stat=%h valid=%b data=%h, expected stat=%h valid=1 data=%h",
                         i, stat(), data_valid, Fifo_Data_out, exp_stat(8 - i), 10'(i));
            end
        end
        pop = 0;
        step();
        tests_run++;
        if ({data_valid, Fifo_Data_out} !== {1'b0, 10'h008}) begin
            failed++;
            $display("FAIL drain_hold: got valid=%b data=%h, expected valid=0 data=008",
                     data_valid, Fifo_Data_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push = 1;
        for (int i = 0; i < 5; i++) begin
            Fifo_Data_in = 10'('h10 + i);
            step();
        end
        push = 0; pop = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({data_valid, Fifo_Data_out} !== {1'b1, 10'('h10 + i)}) begin
                failed++;
                $display("FAIL wrap_first_%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         i, data_valid, Fifo_Data_out, 10'('h10 + i));
            end
        end
        pop = 0; push = 1;
        for (int i = 0; i < 6; i++) begin
            Fifo_Data_in = 10'('h20 + i);
            step();
        end
        push = 0;
        tests_run++;
        if (stat() !== exp_stat(6)) begin
            failed++;
            $display("FAIL wrap_count: got stat=%h, expected %h", stat(), exp_stat(6));
        end
        pop = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if ({data_valid, Fifo_Data_out} !== {1'b1, 10'('h20 + i)}) begin
                failed++;
                $display("FAIL wrap_second_%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         i, data_valid, Fifo_Data_out, 10'('h20 + i));
            end
        end
        pop = 0;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        push = 1;
        for (int i = 0; i < 8; i++) begin
            Fifo_Data_in = 10'('h40 + i);
            step();
        end
        Fifo_Data_in = 10'h155; pop = 1;
        step();
        push = 0;
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(8), 1'b1, 10'h040}) begin
            failed++;
            $display("FAIL full_push_pop: got stat=%h valid=%b data=%h, expected stat=%h valid=1 data=040",
                     stat(), data_valid, Fifo_Data_out, exp_stat(8));
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            tests_run++;
            if (Fifo_Data_out !== ((i == 8) ? 10'h155 : 10'('h40 + i))) begin
                failed++;
                $display("FAIL full_drain_%0d: got data=%h, expected %h", i, Fifo_Data_out,
                         (i == 8) ? 10'h155 : 10'('h40 + i));
            end
        end
        tests_run++;
        if (stat() !== exp_stat(0)) begin
            failed++;
            $display("FAIL full_drain_empty: got stat=%h, expected %h", stat(), exp_stat(0));
        end
        pop = 0;
        step();
        push = 1; pop = 1; Fifo_Data_in = 10'h2AA;
        step();
        push = 0;
        tests_run++;
        if ({stat(), data_valid} !== {exp_stat(1), 1'b0}) begin
            failed++;
            $display("FAIL empty_push_pop: got stat=%h valid=%b, expected stat=%h valid=0",
                     stat(), data_valid, exp_stat(1));
        end
        step();
        pop = 0;
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(0), 1'b1, 10'h2AA}) begin
            failed++;
            $display("FAIL empty_push_pop_read: got stat=%h valid=%b data=%h, expected stat=%h valid=1 data=2aa",
                     stat(), data_valid, Fifo_Data_out, exp_stat(0));
        end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1;
        step();
        pop = 0;
        tests_run++;
        if ({stat(), data_valid, Fifo_Data_out} !== {exp_stat(0), 1'b0, 10'h000}) begin
            failed++;
            $display("FAIL underflow_nochange: got stat=%h valid=%b data=%h, expected stat=%h valid=0 data=000",
                     stat(), data_valid, Fifo_Data_out, exp_stat(0));
        end
`ifdef SYNC_FIFO_ERR_EN
        push = 1; Fifo_Data_in = 10'h001;
        step(); push = 0; pop = 1;
        step(); pop = 0;
        step();
        tests_run++;
        if ({underflow, overflow} !== 2'b10) begin
            failed++;
            $display("FAIL underflow_sticky: got underflow=%b overflow=%b, expected 1 0", underflow, overflow);
        end
        reset_L = 0;
        #2;
        tests_run++;
        if (underflow !== 1'b0) begin
            failed++;
            $display("FAIL underflow_clear: got %b, expected 0", underflow);
        end
        reset_L = 1;
        step(); step(); step();
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
